// File: rtl/decode_ctrl_pipe_if.sv
// Handshake and decode-result bundle between the fetch side and decode_ctrl_pipe.
interface decode_ctrl_pipe_if;
  logic [31:0] instr_i;
  logic        valid_i;
  logic        ready_o;
  logic        stall_i;
  logic        flush_i;
  logic        valid_o;
  logic [8:0]  ctrl_o;
  logic [1:0]  hilo_we_o;
  logic        illegal_o;
  logic        md_busy_o;
  logic        md_done_o;
  logic [1:0]  md_hilo_we_o;

  modport master (
    output instr_i, valid_i, stall_i, flush_i,
    input  ready_o, valid_o, ctrl_o, hilo_we_o, illegal_o,
           md_busy_o, md_done_o, md_hilo_we_o
  );

  modport slave (
    input  instr_i, valid_i, stall_i, flush_i,
    output ready_o, valid_o, ctrl_o, hilo_we_o, illegal_o,
           md_busy_o, md_done_o, md_hilo_we_o
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// MIPS-style decode stage: one-cycle registered control decode plus a
// multiply/divide occupancy tracker that interlocks HI/LO users.
module decode_ctrl_pipe #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input logic               clk,
  input logic               rst,
  decode_ctrl_pipe_if.slave bus
);

  localparam logic [8:0] CTRL_RTYPE = 9'b110000000;
  localparam logic [8:0] CTRL_JR    = 9'b000000100;
  localparam logic [8:0] CTRL_MD    = 9'b000000001;
  localparam logic [8:0] CTRL_LW    = 9'b101001000;
  localparam logic [8:0] CTRL_SW    = 9'b001010000;
  localparam logic [8:0] CTRL_BR    = 9'b000100000;
  localparam logic [8:0] CTRL_IMM   = 9'b101000000;
  localparam logic [8:0] CTRL_J     = 9'b000000100;
  localparam logic [8:0] CTRL_JAL   = 9'b100000110;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT);

  typedef enum logic {IDLE, BUSY} md_state_e;

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic       unused_instr_bits;

  assign op = bus.instr_i[31:26];
  assign fn = bus.instr_i[5:0];
  assign rt = bus.instr_i[20:16];
  assign unused_instr_bits = ^{bus.instr_i[25:21], bus.instr_i[15:6]};

  logic [8:0] dec_ctrl;
  logic [1:0] dec_hilo;
  logic       dec_ill;

  always_comb begin
    dec_ctrl = '0;
    dec_hilo = '0;
    dec_ill  = 1'b0;
    case (op)
      6'b000000: begin
        case (fn)
          6'b001000: dec_ctrl = CTRL_JR;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_ctrl = CTRL_MD;
          6'b010001: dec_hilo = 2'b10;
          6'b010011: dec_hilo = 2'b01;
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b010000, 6'b010010,
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: dec_ctrl = CTRL_RTYPE;
          default:   dec_ill  = 1'b1;
        endcase
      end
      6'b000001: begin
        if (rt == 5'b00000 || rt == 5'b00001) dec_ctrl = CTRL_BR;
        else                                  dec_ill  = 1'b1;
      end
      6'b000010: dec_ctrl = CTRL_J;
      6'b000011: dec_ctrl = CTRL_JAL;
      6'b000100, 6'b000101, 6'b000110, 6'b000111: dec_ctrl = CTRL_BR;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: dec_ctrl = CTRL_IMM;
      6'b100011: dec_ctrl = CTRL_LW;
      6'b101011: dec_ctrl = CTRL_SW;
      default:   dec_ill  = 1'b1;
    endcase
  end

  logic is_md;
  logic is_div;
  logic uses_hilo;

  // MFHI/MTHI/MFLO/MTLO are funct 0100xx, MULT/MULTU/DIV/DIVU are 0110xx
  assign is_md     = (op == 6'b000000) && (fn[5:2] == 4'b0110);
  assign is_div    = fn[1];
  assign uses_hilo = (op == 6'b000000) && (fn[5:4] == 2'b01) && (fn[2] == 1'b0);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       md_busy;
  logic       md_done;
  logic       ready;
  logic       accept;

  assign md_busy = (state_q == BUSY);
  assign ready   = !bus.stall_i && !(md_busy && uses_hilo);
  assign accept  = bus.valid_i && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_md) begin
          state_d = BUSY;
          cnt_d   = is_div ? DIV_CNT : MUL_CNT;
        end
      end
      BUSY: begin
        if (cnt_q == 6'd1) begin
          md_done = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic       valid_q, valid_d;
  logic [8:0] ctrl_q, ctrl_d;
  logic [1:0] hilo_q, hilo_d;
  logic       ill_q, ill_d;

  // Flush beats stall, stall beats accept; anything else drains to a bubble.
  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = '0;
    hilo_d  = '0;
    ill_d   = 1'b0;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (bus.stall_i) begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      hilo_d  = hilo_q;
      ill_d   = ill_q;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl;
      hilo_d  = dec_hilo;
      ill_d   = dec_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      hilo_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      hilo_q  <= hilo_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.ready_o      = ready;
  assign bus.valid_o      = valid_q;
  assign bus.ctrl_o       = ctrl_q;
  assign bus.hilo_we_o    = hilo_q;
  assign bus.illegal_o    = ill_q;
  assign bus.md_busy_o    = md_busy;
  assign bus.md_done_o    = md_done;
  assign bus.md_hilo_we_o = md_done ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed plus random checks of decode_ctrl_pipe against a cycle-numbered
// reference model of decode results and multiply/divide occupancy.
module tb_decode_ctrl_pipe;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 32;

  localparam logic [11:0] R_RTYPE = {3'b000, 9'b110000000};
  localparam logic [11:0] R_JR    = {3'b000, 9'b000000100};
  localparam logic [11:0] R_MD    = {3'b000, 9'b000000001};
  localparam logic [11:0] R_MTHI  = {3'b010, 9'b000000000};
  localparam logic [11:0] R_MTLO  = {3'b001, 9'b000000000};
  localparam logic [11:0] R_LW    = {3'b000, 9'b101001000};
  localparam logic [11:0] R_SW    = {3'b000, 9'b001010000};
  localparam logic [11:0] R_BR    = {3'b000, 9'b000100000};
  localparam logic [11:0] R_IMM   = {3'b000, 9'b101000000};
  localparam logic [11:0] R_J     = {3'b000, 9'b000000100};
  localparam logic [11:0] R_JAL   = {3'b000, 9'b100000110};
  localparam logic [11:0] R_ILL   = {3'b100, 9'b000000000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_ctrl_pipe_if bus ();

  decode_ctrl_pipe #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: cycle number, last MD accept cycle and its latency.
  int         cyc = 0;
  int         md_acc = -1000;
  int         md_lat = 0;
  logic       m_valid;
  logic [8:0] m_ctrl;
  logic [1:0] m_hilo;
  logic       m_ill;

  function automatic logic [11:0] ref_decode(input logic [31:0] ins);
    logic [5:0] op, fn;
    logic [4:0] rt;
    op = ins[31:26];
    fn = ins[5:0];
    rt = ins[20:16];
    if (op == 6'd0) begin
      if (fn == 6'd8) return R_JR;
      if (fn inside {[24:27]}) return R_MD;
      if (fn == 6'd17) return R_MTHI;
      if (fn == 6'd19) return R_MTLO;
      if (fn inside {0, 2, 3, 4, 6, 7, 16, 18, [32:39], 42, 43}) return R_RTYPE;
      return R_ILL;
    end
    if (op == 6'd1) return (rt <= 5'd1) ? R_BR : R_ILL;
    if (op inside {[4:7]}) return R_BR;
    if (op inside {[8:15]}) return R_IMM;
    if (op == 6'd2) return R_J;
    if (op == 6'd3) return R_JAL;
    if (op == 6'd35) return R_LW;
    if (op == 6'd43) return R_SW;
    return R_ILL;
  endfunction

  function automatic bit is_md_instr(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[5:0] inside {[24:27]});
  endfunction

  function automatic bit uses_hilo_instr(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[5:0] inside {16, 17, 18, 19, [24:27]});
  endfunction

  function automatic bit m_busy();
    return (cyc > md_acc) && (cyc <= md_acc + md_lat);
  endfunction

  function automatic bit m_done();
    return (md_lat != 0) && (cyc == md_acc + md_lat);
  endfunction

  function automatic bit m_ready();
    return !bus.stall_i && !(m_busy() && uses_hilo_instr(bus.instr_i));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("valid_o",      32'(bus.valid_o),      32'(m_valid));
    chk("ctrl_o",       32'(bus.ctrl_o),       32'(m_ctrl));
    chk("hilo_we_o",    32'(bus.hilo_we_o),    32'(m_hilo));
    chk("illegal_o",    32'(bus.illegal_o),    32'(m_ill));
    chk("md_busy_o",    32'(bus.md_busy_o),    32'(m_busy()));
    chk("md_done_o",    32'(bus.md_done_o),    32'(m_done()));
    chk("md_hilo_we_o", 32'(bus.md_hilo_we_o), m_done() ? 32'd3 : 32'd0);
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic s, input logic f);
    bus.instr_i = ins;
    bus.valid_i = v;
    bus.stall_i = s;
    bus.flush_i = f;
    #1;
  endtask

  task automatic model_zero();
    m_valid = 1'b0;
    m_ctrl  = '0;
    m_hilo  = '0;
    m_ill   = 1'b0;
    md_acc  = -1000;
    md_lat  = 0;
  endtask

  // One clock: check ready_o, advance the model, check registered outputs.
  task automatic cycle();
    bit          acc;
    logic [11:0] d;
    chk("ready_o", 32'(bus.ready_o), 32'(m_ready()));
    acc = bus.valid_i && m_ready();
    d   = ref_decode(bus.instr_i);
    if (acc && is_md_instr(bus.instr_i)) begin
      md_acc = cyc;
      md_lat = bus.instr_i[1] ? DIV_LAT : MUL_LAT;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.flush_i) begin
      m_valid = 1'b0; m_ctrl = '0; m_hilo = '0; m_ill = 1'b0;
    end else if (bus.stall_i) begin
      // hold
    end else if (acc) begin
      m_valid = 1'b1; m_ctrl = d[8:0]; m_hilo = d[10:9]; m_ill = d[11];
    end else begin
      m_valid = 1'b0; m_ctrl = '0; m_hilo = '0; m_ill = 1'b0;
    end
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, ins;
    int          dn;
    int          t_ready;

    rst = 1'b1;
    bus.instr_i = '0; bus.valid_i = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    model_zero();
    check_outs();
    @(posedge clk); #1;
    check_outs();
    rst = 1'b0;

    // LW accepted, visible next cycle
    drive(32'h8C220004, 1'b1, 1'b0, 1'b0); cycle();
    chk("lw_ctrl", 32'(bus.ctrl_o), 32'h148);

    // JAL then undefined opcode 0x3F
    drive(32'h0C000010, 1'b1, 1'b0, 1'b0); cycle();
    chk("jal_ctrl", 32'(bus.ctrl_o), 32'h106);
    drive(32'hFC000000, 1'b1, 1'b0, 1'b0); cycle();
    chk("ill_ctrl", 32'(bus.ctrl_o), 32'h0);
    chk("ill_flag", 32'(bus.illegal_o), 32'h1);

    // MULT accepted; MFLO waits until the cycle after md_done_o
    drive(32'h00430018, 1'b1, 1'b0, 1'b0); cycle();
    idle(1);
    t_ready = 0;
    for (int i = 0; i < 10 && t_ready == 0; i++) begin
      drive(32'h00000012, 1'b1, 1'b0, 1'b0);
      if (bus.md_done_o) chk("mult_done_hilo", 32'(bus.md_hilo_we_o), 32'h3);
      if (bus.ready_o) t_ready = i + 2;
      cycle();
    end
    chk("mflo_accept_cycle", 32'(t_ready), 32'd5);
    chk("mflo_ctrl", 32'(bus.ctrl_o), 32'h180);

    // DIV busy; ADDI still flows through
    drive(32'h0043001A, 1'b1, 1'b0, 1'b0); cycle();
    drive(32'h20010005, 1'b1, 1'b0, 1'b0);
    chk("addi_ready", 32'(bus.ready_o), 32'h1);
    cycle();
    chk("addi_ctrl", 32'(bus.ctrl_o), 32'h140);
    chk("addi_busy", 32'(bus.md_busy_o), 32'h1);

    // SW registered then stall+flush together; MTHI refused while busy
    drive(32'hAC220004, 1'b1, 1'b0, 1'b0); cycle();
    drive(32'h00400011, 1'b1, 1'b1, 1'b1); cycle();
    chk("flush_valid", 32'(bus.valid_o), 32'h0);
    chk("flush_ctrl", 32'(bus.ctrl_o), 32'h0);

    // stall hold
    drive(32'h8C220004, 1'b1, 1'b0, 1'b0); cycle();
    drive(32'h0C000010, 1'b1, 1'b1, 1'b0); cycle();
    drive(32'h0C000010, 1'b1, 1'b1, 1'b0); cycle();
    chk("stall_hold_ctrl", 32'(bus.ctrl_o), 32'h148);

    // let the divide finish, then MTHI / MTLO
    idle(DIV_LAT);
    drive(32'h00400011, 1'b1, 1'b0, 1'b0); cycle();
    drive(32'h00400013, 1'b1, 1'b0, 1'b0); cycle();

    // reset during a divide aborts it
    drive(32'h0043001A, 1'b1, 1'b0, 1'b0); cycle();
    idle(1);
    rst = 1'b1;
    #1;
    model_zero();
    chk("rst_busy_now", 32'(bus.md_busy_o), 32'h0);
    check_outs();
    @(posedge clk); #1;
    cyc++;
    check_outs();
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      dn += int'(bus.md_done_o);
    end
    chk("no_done_after_rst", 32'(dn), 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom();
      case ($urandom_range(0, 5))
        0: ins = {6'd0, r[25:6], 6'($urandom_range(0, 63))};
        1: ins = {6'd0, r[25:6], 6'($urandom_range(0, 1) ? $urandom_range(16, 19) : $urandom_range(24, 27))};
        2: ins = {6'd1, r[25:21], 3'b000, 2'($urandom_range(0, 3)), r[15:0]};
        3: ins = {6'($urandom_range(0, 15)), r[25:0]};
        4: ins = {($urandom_range(0, 1) ? 6'd35 : 6'd43), r[25:0]};
        default: ins = r;
      endcase
      drive(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 11) == 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning cycles from MULT/MULTU accept to HI/LO write (legal range 2..63).
REQ-002 SHALL have parameter DIV_LAT, default 32, meaning cycles from DIV/DIVU accept to HI/LO write (legal range 2..63).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port instr_i  input  32  instruction; opcode is instr_i[31:26], funct is instr_i[5:0], rt is instr_i[20:16].
REQ-006 SHALL have port valid_i  input  1  instr_i is valid.
REQ-007 SHALL have port ready_o  output  1  stage accepts instr_i this cycle (combinational).
REQ-008 SHALL have port stall_i  input  1  downstream hold; registered outputs keep their values.
REQ-009 SHALL have port flush_i  input  1  kill the registered instruction and insert a bubble.
REQ-010 SHALL have port valid_o  output  1  ctrl_o/hilo_we_o/illegal_o describe a live instruction.
REQ-011 SHALL have port ctrl_o  output  9  bits [8..0] = RegWrite, RegDst, AluSrc, Branch, MemWrite, MemtoReg, Jump, Link, MdStart.
REQ-012 SHALL have port hilo_we_o  output  2  {HI we, LO we} for MTHI/MTLO.
REQ-013 SHALL have port illegal_o  output  1  registered instruction is undefined.
REQ-014 SHALL have ports md_busy_o (output 1, multiply/divide in flight), md_done_o (output 1, one-cycle completion pulse) and md_hilo_we_o (output 2, 2'b11 during md_done_o, else 2'b00).

Function
REQ-015 Decode (9-bit ctrl): R-type (op 000000) SHALL give 110000000; JR (funct 001000) 000000100; MULT/MULTU/DIV/DIVU (funct 011000..011011) 000000001; MTHI/MTLO 000000000.
REQ-016 Decode: LW (100011) 101001000; SW (101011) 001010000; BEQ/BNE/BLEZ/BGTZ (000100..000111) and REGIMM (000001) with rt 00000 or 00001 SHALL give 000100000.
REQ-017 Decode: ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI (001000..001111) 101000000; J (000010) 000000100; JAL (000011) 100000110.
REQ-018 hilo_we_o SHALL be 10 for MTHI (funct 010001), 01 for MTLO (010011), 00 for all other instructions.
REQ-019 Any other opcode, R-type funct, or REGIMM rt SHALL give ctrl 0, hilo_we 00, illegal_o 1.
REQ-020 Accept occurs when valid_i && ready_o; decoded values SHALL appear on outputs with valid_o=1 one cycle later (latency 1).
REQ-021 ready_o SHALL equal !stall_i && !(md_busy_o && instr_i is MFHI/MFLO/MTHI/MTLO/MULT/MULTU/DIV/DIVU).
REQ-022 If stall_i=1 and flush_i=0, all registered outputs SHALL hold.
REQ-023 flush_i SHALL have priority over stall_i and over accept: next cycle valid_o=0, ctrl_o=0, hilo_we_o=0, illegal_o=0.
REQ-024 With no accept, no stall and no flush, next cycle valid_o=0 and ctrl_o/hilo_we_o/illegal_o=0.
REQ-025 MD FSM states: IDLE, BUSY. IDLE->BUSY on accept of MULT/MULTU (counter=MUL_LAT) or DIV/DIVU (counter=DIV_LAT).
REQ-026 In BUSY the counter SHALL decrement each cycle; when it reaches 1, md_done_o=1 and md_hilo_we_o=11 for that cycle, and the next state SHALL be IDLE.
REQ-027 md_busy_o SHALL be 1 exactly in BUSY, so a MULT accepted at edge T gives md_busy_o high for cycles T+1..T+MUL_LAT, with md_done_o in cycle T+MUL_LAT.
REQ-028 flush_i and stall_i SHALL NOT affect the MD FSM or counter.
REQ-029 A HI/LO-using instruction presented in the md_done_o cycle SHALL be refused (ready_o=0) and SHALL be accepted in the following cycle.

Reset
REQ-030 While rst=1: valid_o=0, ctrl_o=0, hilo_we_o=0, illegal_o=0, md_busy_o=0, md_done_o=0, md_hilo_we_o=0, FSM=IDLE, counter=0.
REQ-031 Reset asserted during BUSY SHALL abort the operation, and no md_done_o pulse SHALL follow.

Verification
REQ-032 Reset, then LW 0x8C220004 with valid_i=1 -> next cycle valid_o=1, ctrl_o=101001000.
REQ-033 JAL 0x0C000010, then opcode 0x3F -> ctrl_o=100000110, then ctrl_o=0 with illegal_o=1.
REQ-034 MULT 0x00430018 accepted at T with MUL_LAT=4 -> md_busy_o=1 for T+1..T+4, md_done_o=1 and md_hilo_we_o=11 at T+4; MFLO presented at T+2 -> ready_o=0 until T+5.
REQ-035 DIV accepted, then ADDI presented during BUSY -> ready_o=1, ADDI decoded as 101000000 while md_busy_o stays 1.
REQ-036 stall_i=1 and flush_i=1 in the same cycle with SW registered -> next cycle valid_o=0, ctrl_o=0; MD counter unaffected.
REQ-037 rst pulsed at T+2 of a DIV_LAT=32 divide -> md_busy_o=0 immediately, and no md_done_o for 40 cycles.
